// File: rtl/vram_scanner_if.sv
// Video read port and raster output bundle between vram_scanner and its memory/display neighbours.
interface vram_scanner_if;
  logic       enable;
  logic [7:0] vaddr;
  logic [7:0] vdata;
  logic       pixel;
  logic       de;
  logic       hsync_n;
  logic       vsync_n;
  logic       frame_start;

  modport master (
    input  enable, vdata,
    output vaddr, pixel, de, hsync_n, vsync_n, frame_start
  );

  modport slave (
    output enable, vdata,
    input  vaddr, pixel, de, hsync_n, vsync_n, frame_start
  );
endinterface

// File: rtl/vram_scanner.sv
// Raster timing plus 1-bpp framebuffer walk; pixel/de/sync registered one enabled step after the position.
// All state advances only when enable is high; vaddr always holds the byte for the current position.
module vram_scanner #(
  parameter logic [7:0] FB_BASE      = 8'hE0,
  parameter int         FB_W         = 16,
  parameter int         FB_H         = 16,
  parameter int         SCALE        = 2,
  parameter int         H_TOTAL      = 40,
  parameter int         H_SYNC_START = 34,
  parameter int         H_SYNC_END   = 37,
  parameter int         V_TOTAL      = 36,
  parameter int         V_SYNC_START = 33,
  parameter int         V_SYNC_END   = 34
) (
  input logic             clock,
  input logic             reset,
  vram_scanner_if.master  vif
);

  localparam int ACT_W = FB_W * SCALE;
  localparam int ACT_H = FB_H * SCALE;
  localparam int BPL   = FB_W / 8;
  localparam int HW    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [7:0]    vaddr_q, vaddr_d;
  logic          pixel_q, pixel_d;
  logic          de_q, de_d;
  logic          hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic          frame_start_q, frame_start_d;

  int            h, v, hn, vn, px, addr;
  logic          active;
  logic [2:0]    bit_idx;

  always_comb begin
    h    = int'(hcount_q);
    v    = int'(vcount_q);
    hn   = h + 1;
    vn   = v;
    if (hn >= H_TOTAL) begin
      hn = 0;
      vn = (v >= V_TOTAL - 1) ? 0 : v + 1;
    end

    active  = (h < ACT_W) && (v < ACT_H);
    px      = h / SCALE;
    bit_idx = 3'(7 - (px % 8));

    // Address for the next position; blanking parks on the next active line's first byte.
    if ((hn < ACT_W) && (vn < ACT_H)) begin
      addr = int'(FB_BASE) + (vn / SCALE) * BPL + (hn / SCALE) / 8;
    end else if ((vn < ACT_H) && (vn + 1 < ACT_H)) begin
      addr = int'(FB_BASE) + ((vn + 1) / SCALE) * BPL;
    end else begin
      addr = int'(FB_BASE);
    end

    hcount_d      = HW'(hn);
    vcount_d      = VW'(vn);
    vaddr_d       = 8'(addr);
    de_d          = active;
    pixel_d       = active & vif.vdata[bit_idx];
    hsync_n_d     = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    vsync_n_d     = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    frame_start_d = (h == 0) && (v == 0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      vaddr_q       <= FB_BASE;
      pixel_q       <= 1'b0;
      de_q          <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else if (vif.enable) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vaddr_q       <= vaddr_d;
      pixel_q       <= pixel_d;
      de_q          <= de_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.vaddr       = vaddr_q;
  assign vif.pixel       = pixel_q;
  assign vif.de          = de_q;
  assign vif.hsync_n     = hsync_n_q;
  assign vif.vsync_n     = vsync_n_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vram_scanner.sv
// Directed bench for vram_scanner: default geometry DUT plus an address-wrap geometry DUT.
module tb_vram_scanner;

  logic       clock;
  logic       reset;
  logic [7:0] ram [0:255];
  int         n_checks;
  int         n_errors;

  logic       pix_r [0:1439];
  logic       de_r  [0:1439];
  logic       hs_r  [0:1439];
  logic       vs_r  [0:1439];
  logic       fs_r  [0:1439];
  logic [7:0] va_r  [0:1439];
  logic       pb_r  [0:199];
  logic [7:0] vb_r  [0:200];
  logic [7:0] pat;
  int         fs_count;
  int         n_x;

  vram_scanner_if vif_a();
  vram_scanner_if vif_b();

  assign vif_a.vdata = ram[vif_a.vaddr];
  assign vif_b.vdata = ram[vif_b.vaddr];

  vram_scanner dut_a (
    .clock (clock),
    .reset (reset),
    .vif   (vif_a)
  );

  vram_scanner #(
    .FB_BASE (8'hF8),
    .FB_W    (16),
    .FB_H    (8),
    .SCALE   (1)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .vif   (vif_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_vaddr"}, vif_a.vaddr, 8'hE0);
    check_val({tag, "_pixel"}, vif_a.pixel, 1'b0);
    check_val({tag, "_de"}, vif_a.de, 1'b0);
    check_val({tag, "_hsync_n"}, vif_a.hsync_n, 1'b1);
    check_val({tag, "_vsync_n"}, vif_a.vsync_n, 1'b1);
    check_val({tag, "_fs"}, vif_a.frame_start, 1'b0);
  endtask

  // Line 0 content: RAM[E0]=81, RAM[E1]=00, each pixel doubled.
  function automatic logic exp_l0_pix(input int h);
    return (h < 2) || (h == 14) || (h == 15);
  endfunction

  function automatic logic [7:0] exp_l0_va(input int h);
    if (h < 16) return 8'hE0;
    if (h < 32) return 8'hE1;
    return 8'hE0;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'hE0] = 8'h81;
    ram[8'hE2] = 8'hFF;
    ram[8'h00] = 8'hA5;

    reset         = 1'b1;
    vif_a.enable  = 1'b1;
    vif_b.enable  = 1'b0;
    tick();
    check_reset("rst0");
    reset = 1'b0;

    // One full frame, recorded per position.
    va_r[0]  = vif_a.vaddr;
    fs_count = 0;
    for (int e = 1; e <= 1440; e++) begin
      tick();
      pix_r[e-1] = vif_a.pixel;
      de_r[e-1]  = vif_a.de;
      hs_r[e-1]  = vif_a.hsync_n;
      vs_r[e-1]  = vif_a.vsync_n;
      fs_r[e-1]  = vif_a.frame_start;
      if (vif_a.frame_start) fs_count++;
      if (e < 1440) va_r[e] = vif_a.vaddr;
    end
    check_val("fs_per_frame", fs_count, 1);

    for (int h = 0; h < 40; h++) begin
      check_val($sformatf("l0_pix_h%0d", h), pix_r[h], exp_l0_pix(h));
      check_val($sformatf("l0_de_h%0d", h), de_r[h], h < 32);
      check_val($sformatf("l0_va_h%0d", h), va_r[h], exp_l0_va(h));
    end
    for (int v = 2; v <= 3; v++) begin
      for (int h = 0; h < 32; h++) begin
        check_val($sformatf("l%0d_pix_h%0d", v, h), pix_r[v*40+h], h < 16);
        check_val($sformatf("l%0d_va_h%0d", v, h), va_r[v*40+h], (h < 16) ? 8'hE2 : 8'hE3);
      end
    end
    check_val("l1_blank_va", va_r[1*40+35], 8'hE2);
    for (int v = 30; v <= 31; v++) begin
      for (int h = 0; h < 32; h++) begin
        check_val($sformatf("l%0d_va_h%0d", v, h), va_r[v*40+h], (h < 16) ? 8'hFE : 8'hFF);
      end
    end
    check_val("l31_blank_va", va_r[31*40+35], 8'hE0);
    check_val("l33_va", va_r[33*40], 8'hE0);
    for (int v = 32; v < 36; v++) begin
      for (int h = 0; h < 40; h++) begin
        check_val($sformatf("l%0d_de_h%0d", v, h), de_r[v*40+h], 1'b0);
      end
    end
    for (int v = 0; v < 36; v++) begin
      for (int h = 0; h < 40; h++) begin
        check_val($sformatf("hs_v%0d_h%0d", v, h), hs_r[v*40+h], !(h >= 34 && h <= 36));
        check_val($sformatf("vs_v%0d_h%0d", v, h), vs_r[v*40+h], v != 33);
        check_val($sformatf("fs_v%0d_h%0d", v, h), fs_r[v*40+h], (v == 0) && (h == 0));
      end
    end
    tick();
    check_val("f2_fs", vif_a.frame_start, 1'b1);
    check_val("f2_pix", vif_a.pixel, 1'b1);
    check_val("f2_de", vif_a.de, 1'b1);

    // Enable gating across line 0: each position held for two clocks.
    reset = 1'b1;
    tick();
    check_reset("rst1");
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        vif_a.enable = (ph == 0);
        tick();
        check_val($sformatf("gate_pix_k%0d_p%0d", k, ph), vif_a.pixel, exp_l0_pix(k));
        check_val($sformatf("gate_de_k%0d_p%0d", k, ph), vif_a.de, k < 32);
        check_val($sformatf("gate_va_k%0d_p%0d", k, ph), vif_a.vaddr, exp_l0_va(k + 1));
        check_val($sformatf("gate_fs_k%0d_p%0d", k, ph), vif_a.frame_start, k == 0);
      end
    end

    // Reset mid-frame at (20,10).
    vif_a.enable = 1'b1;
    repeat (380) tick();
    check_val("mid_va_h20_v10", vif_a.vaddr, 8'hEB);
    reset = 1'b1;
    tick();
    check_reset("rst_mid");
    reset = 1'b0;
    tick();
    check_val("post_rst_fs", vif_a.frame_start, 1'b1);
    check_val("post_rst_de", vif_a.de, 1'b1);
    check_val("post_rst_pix", vif_a.pixel, 1'b1);
    check_val("post_rst_va", vif_a.vaddr, 8'hE0);

    // Wrap geometry: base F8, 16x8, no scaling.
    vif_a.enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("b_rst_va", vif_b.vaddr, 8'hF8);
    vif_b.enable = 1'b1;
    vb_r[0] = vif_b.vaddr;
    n_x = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      pb_r[e-1] = vif_b.pixel;
      vb_r[e]   = vif_b.vaddr;
      if ($isunknown(vif_b.vaddr)) n_x++;
    end
    check_val("b_vaddr_known", n_x, 0);
    check_val("b_l3_va0", vb_r[3*40+0], 8'hFE);
    check_val("b_l3_va8", vb_r[3*40+8], 8'hFF);
    check_val("b_l3_blank_va", vb_r[3*40+20], 8'h00);
    check_val("b_l4_va0", vb_r[4*40+0], 8'h00);
    check_val("b_l4_va8", vb_r[4*40+8], 8'h01);
    pat = 8'hA5;
    for (int h = 0; h < 8; h++) begin
      check_val($sformatf("b_l4_pix_h%0d", h), pb_r[4*40+h], pat[7-h]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_scanner.md
Name: vram_scanner

Overview:
- Video read-out stage that consumes the memory's video read port (vaddr -> vdata, combinational read).
- Generates raster timing and walks a 1-bpp framebuffer region of the 256-byte RAM.
- Emits a registered pixel stream with data-enable, hsync and vsync for the display stage downstream.
- Each framebuffer pixel is replicated SCALE times horizontally and SCALE lines vertically.

Parameters:
- FB_BASE, 8'hE0, byte address of framebuffer pixel (0,0).
- FB_W, 16, framebuffer width in pixels; must be a multiple of 8.
- FB_H, 16, framebuffer height in pixels.
- SCALE, 2, pixel replication factor; integer >= 1.
- H_TOTAL, 40, clock-enabled steps per line; must be >= FB_W*SCALE.
- H_SYNC_START, 34, first hcount with hsync asserted.
- H_SYNC_END, 37, first hcount after the hsync pulse.
- V_TOTAL, 36, lines per frame; must be >= FB_H*SCALE.
- V_SYNC_START, 33, first vcount with vsync asserted.
- V_SYNC_END, 34, first vcount after the vsync pulse.

Ports:
- clock  input  1  system clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  pixel-step enable; counters and outputs advance only when high.
- vaddr  output  8  video read address to memory; registered.
- vdata  input  8  byte at vaddr; combinational from memory.
- pixel  output  1  current pixel value.
- de  output  1  data enable; high during the active area.
- hsync_n  output  1  horizontal sync, active-low.
- vsync_n  output  1  vertical sync, active-low.
- frame_start  output  1  one-step pulse marking position (0,0).

Behaviour:
- Reset: synchronous, active-high. On the edge that samples reset high:
  - hcount = 0, vcount = 0, vaddr = FB_BASE.
  - pixel = 0, de = 0, hsync_n = 1, vsync_n = 1, frame_start = 0.
  - Reset overrides enable.
  - Reset mid-frame: the next enabled step processes position (0,0).
- Counters:
  - hcount runs 0..H_TOTAL-1 and wraps to 0. On that wrap, vcount increments.
  - vcount runs 0..V_TOTAL-1 and wraps to 0.
  - Counters advance only on cycles where enable = 1.
- Active area: hcount < FB_W*SCALE and vcount < FB_H*SCALE.
  - px = hcount / SCALE, py = vcount / SCALE (integer division).
- Address:
  - In every cycle whose current position is active, vaddr = (FB_BASE + py*(FB_W/8) + px/8) mod 256. Addresses wrap at 8 bits.
  - Outside the active area, vaddr holds the address of the next active byte, i.e. the first byte of the next active line or FB_BASE.
  - vaddr is a register, so it is computed from next-position values.
- Pixel select: bit = vdata[7 - (px mod 8)]; bit 7 is the leftmost pixel.
- Output latency: outputs are registered with 1-step latency. On an enabled cycle at position (h,v), the next edge loads:
  - de = active(h,v).
  - pixel = active ? selected bit : 0.
  - hsync_n = !(H_SYNC_START <= h < H_SYNC_END).
  - vsync_n = !(V_SYNC_START <= v < V_SYNC_END).
  - frame_start = (h==0 && v==0).
- enable = 0: all outputs and vaddr hold, and frame_start holds its value. Sinks must qualify frame_start with enable.
- Sync timing: hsync is evaluated on every line, including blanked lines. vsync is level-based on vcount for whole lines.
- Memory access: the block never writes memory and uses no handshake with it. vdata is sampled in the same cycle vaddr is presented.
- Size: no internal state beyond the counters, vaddr and the output registers. Expected RTL is about 150 lines.

Test Plan:
- Reset, enable=1, RAM[E0]=8'b1000_0001, RAM[E1]=0, defaults:
  - At edges 1-2, pixel = 1 and de = 1.
  - At edges 3-14, pixel = 0.
  - At edges 15-16, pixel = 1.
  - At edges 17-32, pixel = 0; de falls at edge 33.
  - vaddr = E0 for hcount 0-15 and E1 for hcount 16-31.
- Line addressing, defaults, RAM[E2]=8'hFF:
  - vcount 2 and 3 both fetch E2/E3; pixel = 1 for hcount 0-15 on both lines.
  - vcount 30 and 31 fetch FE/FF.
  - vcount 32-35 keep de = 0 for the whole line.
- Sync timing, defaults:
  - hsync_n = 0 on the outputs following hcount 34, 35, 36 of every line, including blanked ones.
  - vsync_n = 0 for the entire line following vcount 33.
  - frame_start pulses once per 1440 enabled steps.
- Address wrap, FB_BASE=8'hF8, FB_W=16, FB_H=8, SCALE=1:
  - Line 3 reads FE, FF.
  - Line 4 reads 00, 01; no X on vaddr.
- Enable gating, enable toggled 1,0,1,0 during an active line:
  - Each position lasts exactly 2 clocks.
  - Outputs and vaddr hold on enable=0 cycles.
  - The pixel sequence is identical to the enable=1 run.
- Reset mid-frame, reset asserted at hcount=20, vcount=10 for 1 cycle:
  - The following edge shows reset values.
  - The next enabled step yields frame_start = 1, de = 1, and vaddr = E0 again.
